// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mult_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NUM_REQ = 2;
  localparam int OPW     = 8;
  localparam int PRODW   = 2 * OPW;

endpackage

// File: rtl/eight_bit_multiplier_structural_module.sv
// Unsigned 8x8 array multiplier: one ripple-carry adder row per multiplier bit.
module eight_bit_multiplier_structural_module
  import mult_share_arbiter_pkg::*;
(
  input  logic [OPW-1:0]   a_i,
  input  logic [OPW-1:0]   b_i,
  output logic [PRODW-1:0] product_o
);

  for (genvar gi = 0; gi < OPW; gi++) begin : g_row
    logic [PRODW-1:0] addend;
    logic [PRODW-1:0] prev;
    logic [PRODW-1:0] sum;

    // Partial product for multiplier bit gi, aligned to its weight.
    assign addend = {{OPW{1'b0}}, a_i & {OPW{b_i[gi]}}} << gi;

    if (gi == 0) begin : g_base
      assign prev = '0;
    end else begin : g_chain
      assign prev = g_row[gi-1].sum;
    end

    always_comb begin : p_ripple
      logic c;
      c   = 1'b0;
      sum = '0;
      for (int j = 0; j < PRODW; j++) begin
        sum[j] = prev[j] ^ addend[j] ^ c;
        c      = (prev[j] & addend[j]) | (c & (prev[j] ^ addend[j]));
      end
    end
  end

  assign product_o = g_row[OPW-1].sum;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one structural 8x8 multiplier between two
// requesters; each grant runs IDLE -> CALC (fixed settle time) -> RESP.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int CALC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [15:0] resp0_result,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [15:0] resp1_result,
  output logic        busy,
  output logic        grant_id
);

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [OPW-1:0]     a_q, b_q, a_d, b_d;
  logic [PRODW-1:0]   result_q, product;
  logic               grant_q, prio_q, rst_hold_q;
  logic               winner_d, accept;
  logic [NUM_REQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [PRODW-1:0]   resp_result [NUM_REQ];

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    winner_d = prio_q;
    if (req_valid == 2'b01) winner_d = 1'b0;
    else if (req_valid == 2'b10) winner_d = 1'b1;
  end

  assign a_d = winner_d ? req1_a : req0_a;
  assign b_d = winner_d ? req1_b : req0_b;

  // No acceptance during reset or in the first cycle after it.
  assign accept = (state_q == IDLE) && (|req_valid) && !reset && !rst_hold_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    assign req_ready[gi]   = accept && (winner_d == 1'(gi));
    assign resp_valid[gi]  = !reset && (state_q == RESP) && (grant_q == 1'(gi));
    assign resp_result[gi] = resp_valid[gi] ? result_q : '0;
  end

  assign req0_ready   = req_ready[0];
  assign req1_ready   = req_ready[1];
  assign resp0_valid  = resp_valid[0];
  assign resp1_valid  = resp_valid[1];
  assign resp0_result = resp_result[0];
  assign resp1_result = resp_result[1];
  assign busy         = !reset && (state_q != IDLE);
  assign grant_id     = !reset && grant_q;

  eight_bit_multiplier_structural_module u_mult (
    .a_i       (a_q),
    .b_i       (b_q),
    .product_o (product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      rst_hold_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a_d;
            b_q     <= b_d;
            grant_q <= winner_d;
            cnt_q   <= 4'(CALC_CYCLES - 1);
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == 4'd0) begin
            result_q <= product;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (|(resp_valid & resp_ready)) begin
            prio_q  <= ~grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
